// File: rtl/cla4_seq_adder_if.sv
// Request/result bundle for the nibble-serial adder.
// The requester drives the operands and start; the adder returns the handshake, result and flags.

interface cla4_seq_adder_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cOut;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b, cIn,
    input  ready, done, s, cOut, overflow, zero
  );

  modport slave (
    input  start, sub, a, b, cIn,
    output ready, done, s, cOut, overflow, zero
  );
endinterface

// File: rtl/cla4_seq_adder.sv
// Multi-cycle adder/subtractor: one 4-bit carry-lookahead slice is stepped over the
// operands LSB nibble first, with the slice carry-out registered as the next carry-in.

module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

module cla4_seq_adder #(
  parameter int WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  cla4_seq_adder_if.slave   bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  generate
    if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_badWidth
      $error("cla4_seq_adder: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_cOut;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [CW+1:0]    w_base;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_sNext;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);
  assign w_base   = {r_cnt, 2'b00};

  cla4 u_slice (
    .i_a    (r_a[w_base +: 4]),
    .i_b    (r_b[w_base +: 4]),
    .i_c    (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // The zero flag must see the final nibble, so it is computed from the merged result.
  always_comb begin
    w_sNext                = r_s;
    w_sNext[w_base +: 4]   = w_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_stateNext = RUN;
      RUN:     if (r_cnt == LAST) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so B is inverted once at accept and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cOut  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub | bus.cIn;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cOut  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (r_state == RUN) begin
      r_s     <= w_sNext;
      r_carry <= w_cout;
      if (w_last) begin
        r_cnt  <= '0;
        r_cOut <= w_cout;
        r_ovf  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[3] ^ w_cout;
        r_zero <= (w_sNext == '0);
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign bus.ready    = (r_state == IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.s        = r_s;
  assign bus.cOut     = r_cOut;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
endmodule

// File: tb/tb_cla4_seq_adder.sv
// Bench for cla4_seq_adder: directed 16-bit cases with literal expectations, then a
// 64-bit back-to-back random stream checked cycle by cycle against an arithmetic model.

module tb_cla4_seq_adder;
  localparam int PERIOD = 18;
  localparam int NOPS   = 1000;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cIn;
  } op_t;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst16;
  logic rst64;
  int   checks = 0;
  int   errors = 0;
  bit   chk64En = 1'b0;
  int   m64 = 0;
  op_t  opQ[$];
  res_t lastRes;

  always #5 clk = ~clk;

  cla4_seq_adder_if #(.WIDTH(16)) bus16 ();
  cla4_seq_adder_if #(.WIDTH(64)) bus64 ();

  cla4_seq_adder #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst16), .bus(bus16.slave));
  cla4_seq_adder #(.WIDTH(64)) dut64 (.clk(clk), .reset(rst64), .bus(bus64.slave));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Plain wide arithmetic: subtraction as a + two's complement of b, overflow from sign rules.
  function automatic res_t refModel(input op_t op);
    res_t        r;
    logic [63:0] bb;
    logic [64:0] full;
    bb   = op.sub ? (~op.b + 64'd1) : op.b;
    full = {1'b0, op.a} + {1'b0, ~op.b} + 65'd1;
    if (!op.sub) full = {1'b0, op.a} + {1'b0, op.b} + {64'd0, op.cIn};
    r.s  = full[63:0];
    r.c  = full[64];
    r.v  = op.sub ? ((op.a[63] != op.b[63]) && (r.s[63] != op.a[63]))
                  : ((op.a[63] == op.b[63]) && (r.s[63] != op.a[63]));
    r.z  = (r.s == 64'd0);
    if (bb == 64'd0) r.z = (r.s == 64'd0);
    return r;
  endfunction

  task automatic applyStimulus(input logic sub, input logic [15:0] a, input logic [15:0] b,
                               input logic cIn);
    @(negedge clk);
    bus16.sub   = sub;
    bus16.a     = a;
    bus16.b     = b;
    bus16.cIn   = cIn;
    bus16.start = 1'b1;
    @(posedge clk);
  endtask

  task automatic runDirected(input string name, input logic sub, input logic [15:0] a,
                             input logic [15:0] b, input logic cIn, input logic [15:0] expS,
                             input logic expC, input logic expV, input logic expZ,
                             input bit disturb);
    applyStimulus(sub, a, b, cIn);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      checkOutput({name, " done"}, bus16.done, (k == 4));
      checkOutput({name, " ready"}, bus16.ready, (k >= 5));
      if (k == 0) begin
        checkOutput({name, " s cleared"}, bus16.s, 0);
        checkOutput({name, " flags cleared"}, {bus16.cOut, bus16.overflow, bus16.zero}, 0);
        bus16.start = 1'b0;
      end
      if (k == 4 || k == 7) begin
        checkOutput({name, " s"}, bus16.s, expS);
        checkOutput({name, " cOut"}, bus16.cOut, expC);
        checkOutput({name, " overflow"}, bus16.overflow, expV);
        checkOutput({name, " zero"}, bus16.zero, expZ);
      end
      if (disturb && k == 1) begin
        bus16.a     = 16'hFFFF;
        bus16.b     = 16'hFFFF;
        bus16.sub   = 1'b1;
        bus16.cIn   = 1'b1;
        bus16.start = 1'b1;
      end
      if (disturb && k == 2) bus16.start = 1'b0;
    end
  endtask

  task automatic randomOp(output op_t op);
    int sel;
    op.a   = {$urandom(), $urandom()};
    op.b   = {$urandom(), $urandom()};
    op.sub = 1'($urandom_range(0, 1));
    op.cIn = 1'($urandom_range(0, 1));
    sel    = $urandom_range(0, 7);
    if (sel == 0) op.b = ~op.a;
    if (sel == 1) op.b = op.a;
    if (sel == 2) op.a = 64'h7FFF_FFFF_FFFF_FFFF;
  endtask

  task automatic drive64(input op_t op);
    bus64.a   = op.a;
    bus64.b   = op.b;
    bus64.sub = op.sub;
    bus64.cIn = op.cIn;
  endtask

  // Every cycle of the random stream: done/ready follow the fixed 18-cycle cadence and the
  // result presented with done (and still held the cycle after) matches the model.
  always @(negedge clk) begin
    if (chk64En) begin
      int   phase;
      op_t  op;
      phase = m64 % PERIOD;
      checkOutput("rand done", bus64.done, (phase == PERIOD - 2));
      checkOutput("rand ready", bus64.ready, (phase == PERIOD - 1));
      if (phase == PERIOD - 2) begin
        if (opQ.size() == 0) begin
          checkOutput("rand queue underflow", 64'd1, 64'd0);
        end else begin
          op      = opQ.pop_front();
          lastRes = refModel(op);
          checkOutput("rand s", bus64.s, lastRes.s);
          checkOutput("rand cOut", bus64.cOut, lastRes.c);
          checkOutput("rand overflow", bus64.overflow, lastRes.v);
          checkOutput("rand zero", bus64.zero, lastRes.z);
        end
      end
      if (phase == PERIOD - 1) begin
        checkOutput("rand s held", bus64.s, lastRes.s);
      end
      m64++;
    end
  end

  initial begin
    op_t op;
    rst16 = 1'b1;
    rst64 = 1'b1;
    bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cIn = 1'b0;
    bus64.start = 1'b0; bus64.sub = 1'b0; bus64.a = '0; bus64.b = '0; bus64.cIn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst16 = 1'b0;
    rst64 = 1'b0;
    @(negedge clk);
    checkOutput("reset ready16", bus16.ready, 1);
    checkOutput("reset done16", bus16.done, 0);
    checkOutput("reset s16", bus16.s, 0);
    checkOutput("reset flags16", {bus16.cOut, bus16.overflow, bus16.zero}, 0);
    checkOutput("reset ready64", bus64.ready, 1);
    checkOutput("reset done64", bus64.done, 0);
    checkOutput("reset s64", bus64.s, 0);
    checkOutput("reset flags64", {bus64.cOut, bus64.overflow, bus64.zero}, 0);

    runDirected("add FFFF+1",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    runDirected("add 7FFF+1c", 1'b0, 16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0);
    runDirected("sub 5-7",     1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    runDirected("sub 8000-1",  1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    runDirected("ignore start", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b0, 16'h0003, 16'h0004, 1'b0);
    @(negedge clk);
    bus16.start = 1'b0;
    @(negedge clk);
    checkOutput("partial nibble0", bus16.s, 16'h0007);
    rst16 = 1'b1;
    @(negedge clk);
    rst16 = 1'b0;
    checkOutput("midrun reset ready", bus16.ready, 1);
    checkOutput("midrun reset done", bus16.done, 0);
    checkOutput("midrun reset s", bus16.s, 0);
    checkOutput("midrun reset flags", {bus16.cOut, bus16.overflow, bus16.zero}, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("post reset no done", bus16.done, 0);
      checkOutput("post reset ready", bus16.ready, 1);
    end
    runDirected("add 1+1", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    randomOp(op);
    drive64(op);
    opQ.push_back(op);
    bus64.start = 1'b1;
    @(posedge clk);
    #1;
    chk64En = 1'b1;
    for (int m = 1; m <= PERIOD * NOPS; m++) begin
      randomOp(op);
      drive64(op);
      if (m == PERIOD * NOPS) bus64.start = 1'b0;
      else if ((m % PERIOD) == 0) opQ.push_back(op);
      @(posedge clk);
      #1;
    end
    chk64En = 1'b0;
    checkOutput("rand ops drained", opQ.size(), 0);
    checkOutput("rand cycles seen", m64, PERIOD * NOPS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
